// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous RAM.
// Supports locked bursts and returns read data in order, tagged to its owner.
module ram_port_arbiter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;          // 0: A preferred, 1: B preferred
  logic   grant_a, grant_b;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] own_q, own_d;  // 1: read belongs to B
  logic [DATA_W-1:0]       a_hold_q, a_hold_d;
  logic [DATA_W-1:0]       b_hold_q, b_hold_d;
  logic                    ret_vld;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        grant_a = a_valid && (!b_valid || !prio_q);
        grant_b = b_valid && (!a_valid ||  prio_q);
      end
      LOCK_A:  grant_a = a_valid;
      LOCK_B:  grant_b = b_valid;
      default: ;
    endcase
    // No grant is issued in the reset cycle, so no beat can slip past a reset.
    if (reset) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end

    state_d = state_q;
    prio_d  = prio_q;
    if (grant_a) begin
      prio_d  = 1'b1;
      state_d = a_lock ? LOCK_A : IDLE;
    end else if (grant_b) begin
      prio_d  = 1'b0;
      state_d = b_lock ? LOCK_B : IDLE;
    end
  end

  always_comb begin
    a_ready   = grant_a;
    b_ready   = grant_b;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (grant_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  always_comb begin
    vld_d    = (vld_q << 1) | READ_LATENCY'((grant_a && !a_we) || (grant_b && !b_we));
    own_d    = (own_q << 1) | READ_LATENCY'(grant_b);
    ret_vld  = vld_q[READ_LATENCY-1] && !reset;
    a_rvalid = ret_vld && !own_q[READ_LATENCY-1];
    b_rvalid = ret_vld &&  own_q[READ_LATENCY-1];
    a_hold_d = a_rvalid ? mem_rdata : a_hold_q;
    b_hold_d = b_rvalid ? mem_rdata : b_hold_q;
    a_rdata  = reset ? '0 : a_hold_d;
    b_rdata  = reset ? '0 : b_hold_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      vld_q    <= '0;
      own_q    <= '0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
    end
  end

endmodule
